// File: rtl/ccff_loader_pkg.sv
// Shared state encoding and CRC-16-CCITT constants for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MSB-first register update with a single serial input bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator; one input bit folded per enabled cycle.
// Latency: crc reflects a bit on the cycle after it is enabled. No backpressure.
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= 16'h0000;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes configuration words LSB-first onto the ccff chain head; CCFF_TAIL_CRC_EN adds tail readback CRC.
// Latency: first bit on ccff_head one cycle after the accepting handshake; no bubble on back-to-back words.
// Backpressure: cfg_ready only in LOAD or on the last bit of a word; ccff_shift_en drops while starved.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [15:0]       tail_crc
);

  localparam int               REM_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(WORD_W - 1);

  state_t            state_q, state_n;
  logic [WORD_W-1:0] shreg_q, shreg_n;
  logic [REM_W-1:0]  rem_q, rem_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              head_n, shift_n, done_n;
  logic              take_word, crc_clear;

  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      rem_q         <= '0;
      bit_count     <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_n;
      shreg_q       <= shreg_n;
      rem_q         <= rem_n;
      bit_count     <= cnt_n;
      ccff_head     <= head_n;
      ccff_shift_en <= shift_n;
      done          <= done_n;
    end
  end

  // rem_q counts bits of the current word still waiting behind the one on ccff_head.
  always_comb begin
    state_n   = state_q;
    shreg_n   = shreg_q;
    rem_n     = rem_q;
    cnt_n     = bit_count;
    head_n    = 1'b0;
    shift_n   = 1'b0;
    done_n    = done;
    cfg_ready = 1'b0;
    crc_clear = 1'b0;
    take_word = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n   = LOAD;
          done_n    = 1'b0;
          cnt_n     = '0;
          crc_clear = 1'b1;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        take_word = cfg_valid;
      end
      SHIFT: begin
        if (bit_count == LAST_CNT) begin
          // Chain full: leftover bits of a partial word are dropped.
          state_n = DONE;
          done_n  = 1'b1;
          shreg_n = '0;
          rem_n   = '0;
        end else if (rem_q != '0) begin
          head_n  = shreg_q[0];
          shreg_n = shreg_q >> 1;
          rem_n   = rem_q - 1'b1;
          cnt_n   = bit_count + 1'b1;
          shift_n = 1'b1;
        end else begin
          cfg_ready = 1'b1;
          take_word = cfg_valid;
          if (!cfg_valid) begin
            state_n = LOAD;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (take_word) begin
      state_n = SHIFT;
      head_n  = cfg_data[0];
      shreg_n = cfg_data >> 1;
      rem_n   = REM_FULL;
      cnt_n   = bit_count + 1'b1;
      shift_n = 1'b1;
    end
  end

  assign busy = (state_q == LOAD) || (state_q == SHIFT);

`ifdef CCFF_TAIL_CRC_EN
  ccff_crc16_serial u_crc (
    .clk    (prog_clk),
    .rst_n  (prog_rst_n),
    .clear  (crc_clear),
    .enable (ccff_shift_en),
    .din    (ccff_tail),
    .crc    (tail_crc)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail ^ crc_clear;
  assign tail_crc    = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader with WORD_W=8, CHAIN_LEN=20.
module tb_ccff_bitstream_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;
  localparam int CNT_W     = 5;

  logic              prog_clk   = 1'b0;
  logic              prog_rst_n = 1'b0;
  logic              start      = 1'b0;
  logic [WORD_W-1:0] cfg_data   = '0;
  logic              cfg_valid  = 1'b0;
  logic              ccff_tail  = 1'b0;
  logic              cfg_ready, ccff_head, ccff_shift_en, busy, done;
  logic [CNT_W-1:0]  bit_count;
  logic [15:0]       tail_crc;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(
    .WORD_W    (WORD_W),
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .prog_clk      (prog_clk),
    .prog_rst_n    (prog_rst_n),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .bit_count     (bit_count),
    .tail_crc      (tail_crc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Chain-side monitor: records shifted bits, longest enable run and gap lengths.
  logic        mon_clr = 1'b0;
  logic [31:0] bits_q  = '0;
  int          n_bits  = 0;
  int          max_run = 0;
  int          cur_run = 0;
  int          low_run = 0;
  int          gaps[$];

  initial begin
    forever begin
      @(negedge prog_clk);
      if (mon_clr) begin
        bits_q  = '0;
        n_bits  = 0;
        max_run = 0;
        cur_run = 0;
        low_run = 0;
        gaps.delete();
      end else if (ccff_shift_en) begin
        if (n_bits < 32) bits_q[n_bits] = ccff_head;
        n_bits++;
        if (low_run > 0) gaps.push_back(low_run);
        low_run = 0;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
        if (n_bits > 0) low_run++;
      end
    end
  end

  logic [WORD_W-1:0] words [3] = '{8'hA5, 8'h3C, 8'h0F};

  task automatic tick(input int n);
    repeat (n) @(negedge prog_clk);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick(2);
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_hs(input string tag);
    for (int k = 0; k < 64; k++) begin
      if (cfg_ready) break;
      @(negedge prog_clk);
    end
    check(tag, cfg_ready, 1);
    tick(1);
  endtask

  task automatic send_stream(input int gap);
    for (int w = 0; w < 3; w++) begin
      if (w > 0 && gap > 0) begin
        for (int k = 0; k < 64; k++) begin
          if (cfg_ready && !ccff_shift_en) break;
          @(negedge prog_clk);
        end
        tick(gap);
      end
      cfg_data  = words[w];
      cfg_valid = 1'b1;
      wait_hs("handshake");
      cfg_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100; k++) begin
      if (done) break;
      @(negedge prog_clk);
    end
    check("done_wait", done, 1);
  endtask

  function automatic logic [15:0] crc_ref_zeros(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  initial begin
    // Reset state
    tick(2);
    check("rst_ready",    cfg_ready, 0);
    check("rst_head",     ccff_head, 0);
    check("rst_shift_en", ccff_shift_en, 0);
    check("rst_busy",     busy, 0);
    check("rst_done",     done, 0);
    check("rst_count",    bit_count, 0);
    check("rst_crc",      tail_crc, 0);

    // cfg_valid in IDLE is ignored
    prog_rst_n = 1'b1;
    cfg_data   = 8'hFF;
    cfg_valid  = 1'b1;
    tick(2);
    check("idle_ready",    cfg_ready, 0);
    check("idle_busy",     busy, 0);
    check("idle_shift_en", ccff_shift_en, 0);
    cfg_valid = 1'b0;

    // Back-to-back stream
    clear_mon();
    pulse_start();
    check("load_busy", busy, 1);
    check("load_done", done, 0);
    send_stream(0);
    wait_done();
    check("b2b_bits",    bits_q, 32'h000F3CA5);
    check("b2b_nbits",   n_bits, 20);
    check("b2b_run",     max_run, 20);
    check("b2b_gaps",    gaps.size(), 0);
    check("b2b_count",   bit_count, 20);
    check("b2b_busy",    busy, 0);
`ifdef CCFF_TAIL_CRC_EN
    check("b2b_crc",     tail_crc, crc_ref_zeros(20));
`else
    check("b2b_crc",     tail_crc, 0);
`endif
    tick(1);
    check("done_sticky", done, 1);
    check("done_ready",  cfg_ready, 0);
    check("done_shift",  ccff_shift_en, 0);

    // Stream with 3-cycle source gaps at word boundaries
    clear_mon();
    pulse_start();
    check("gap_done_clr", done, 0);
    send_stream(3);
    wait_done();
    check("gap_bits",   bits_q, 32'h000F3CA5);
    check("gap_nbits",  n_bits, 20);
    check("gap_ngaps",  gaps.size(), 2);
    check("gap_len0",   (gaps.size() > 0) ? gaps[0] : 0, 4);
    check("gap_len1",   (gaps.size() > 1) ? gaps[1] : 0, 4);
    check("gap_count",  bit_count, 20);

    // Reset after 10 bits, with start asserted at the same time
    clear_mon();
    pulse_start();
    cfg_data  = words[0];
    cfg_valid = 1'b1;
    wait_hs("rst_hs0");
    cfg_data = words[1];
    wait_hs("rst_hs1");
    cfg_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (bit_count == 10) break;
      @(negedge prog_clk);
    end
    check("mid_count10", bit_count, 10);
    prog_rst_n = 1'b0;
    start      = 1'b1;
    tick(1);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_done",  done, 0);
    check("mid_rst_count", bit_count, 0);
    check("mid_rst_shift", ccff_shift_en, 0);
    check("mid_rst_ready", cfg_ready, 0);
    prog_rst_n = 1'b1;
    start      = 1'b0;
    tick(1);
    check("post_rst_busy", busy, 0);

    // Clean reload with stray start pulses while busy
    clear_mon();
    pulse_start();
    fork
      send_stream(0);
      begin
        tick(6);
        pulse_start();
        tick(6);
        pulse_start();
      end
    join
    wait_done();
    check("restart_bits",  bits_q, 32'h000F3CA5);
    check("restart_nbits", n_bits, 20);
    check("restart_run",   max_run, 20);
    check("restart_count", bit_count, 20);
    tick(1);
    check("restart_idle",  busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
